// File: rtl/term_buffer_ctrl_if.sv
// Serial command/response bundle for the terminal text buffer.
// master = command source / transmit sink, slave = buffer controller.
interface term_buffer_ctrl_if #(
    parameter int DW = 8,
    parameter int AW = 10
);
    logic [DW-1:0] i_serial;
    logic          i_serial_v;
    logic          o_busy;
    logic          o_drop;
    logic [DW-1:0] o_serial;
    logic          o_serial_v;
    logic          i_serial_rdy;
    logic [AW-1:0] o_cursor;

    modport master (
        output i_serial, i_serial_v, i_serial_rdy,
        input  o_busy, o_drop, o_serial, o_serial_v, o_cursor
    );

    modport slave (
        input  i_serial, i_serial_v, i_serial_rdy,
        output o_busy, o_drop, o_serial, o_serial_v, o_cursor
    );
endinterface

// File: rtl/term_buffer_ctrl.sv
// Terminal text-buffer controller: ROWS x COLS char RAM, cursor,
// single-byte command decode and ready/valid serial responses.
module term_buffer_ctrl #(
    parameter int             COLS       = 40,
    parameter int             ROWS       = 24,
    parameter int             DW         = 8,
    parameter int             AW         = $clog2(ROWS * COLS),
    parameter int             CURSOR_RST = 0,
    parameter logic [DW-1:0]  FILL       = 'h20
) (
    input logic               clk,
    input logic               rst,
    term_buffer_ctrl_if.slave bus
);
    localparam int N  = ROWS * COLS;
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam logic [AW-1:0] LAST = AW'(N - 1);
    localparam logic [RW-1:0] RMAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] CMAX = CW'(COLS - 1);
    localparam logic [RW-1:0] RRST = RW'(CURSOR_RST / COLS);
    localparam logic [CW-1:0] CRST = CW'(CURSOR_RST % COLS);

    localparam logic [DW-1:0] K_J  = DW'(8'h6A);
    localparam logic [DW-1:0] K_K  = DW'(8'h6B);
    localparam logic [DW-1:0] K_H  = DW'(8'h68);
    localparam logic [DW-1:0] K_L  = DW'(8'h6C);
    localparam logic [DW-1:0] K_W  = DW'(8'h77);
    localparam logic [DW-1:0] K_C  = DW'(8'h63);
    localparam logic [DW-1:0] K_SP = DW'(8'h20);
    localparam logic [DW-1:0] K_Q  = DW'(8'h3F);

    typedef enum logic [2:0] {
        IDLE, RD, RSP, WCHAR, CLEAR, DUMP, POS_ROW, POS_COL
    } state_t;

    state_t        state, state_n;
    logic [RW-1:0] row, row_n;
    logic [CW-1:0] col, col_n;
    logic [AW-1:0] cursor, cnt, addr;
    logic [DW-1:0] mem [N];
    logic [DW-1:0] rdata, wdata, tx;
    logic          we, tx_v, go, pend, drop;
    logic          busy, acc, hs;

    assign busy = (state != IDLE) && (state != WCHAR);
    assign acc  = bus.i_serial_v && !busy;
    assign hs   = tx_v && bus.i_serial_rdy;

    assign bus.o_busy     = busy;
    assign bus.o_drop     = drop;
    assign bus.o_serial   = tx;
    assign bus.o_serial_v = tx_v;
    assign bus.o_cursor   = cursor;

    always_comb begin
        state_n = state;
        row_n   = row;
        col_n   = col;
        we      = 1'b0;
        wdata   = bus.i_serial;
        addr    = cursor;
        unique case (state)
            IDLE: if (acc) begin
                unique case (1'b1)
                    bus.i_serial == K_J: begin
                        if (row != RMAX) row_n = row + 1'b1;
                        state_n = RD;
                    end
                    bus.i_serial == K_K: begin
                        if (row != '0) row_n = row - 1'b1;
                        state_n = RD;
                    end
                    bus.i_serial == K_H: begin
                        if (col != '0) col_n = col - 1'b1;
                        state_n = RD;
                    end
                    bus.i_serial == K_L: begin
                        if (col != CMAX) col_n = col + 1'b1;
                        state_n = RD;
                    end
                    bus.i_serial == K_W:  state_n = WCHAR;
                    bus.i_serial == K_C:  state_n = CLEAR;
                    bus.i_serial == K_SP: state_n = DUMP;
                    bus.i_serial == K_Q:  state_n = POS_ROW;
                    default: ;
                endcase
            end
            RD:  state_n = RSP;
            RSP: if (hs) state_n = IDLE;
            WCHAR: if (bus.i_serial_v) begin
                we = 1'b1;
                if (col == CMAX) begin
                    col_n = '0;
                    row_n = (row == RMAX) ? '0 : row + 1'b1;
                end else begin
                    col_n = col + 1'b1;
                end
                state_n = IDLE;
            end
            CLEAR: begin
                we    = 1'b1;
                addr  = cnt;
                wdata = FILL;
                if (cnt == LAST) begin
                    row_n   = '0;
                    col_n   = '0;
                    state_n = IDLE;
                end
            end
            DUMP: begin
                // next cell is read on the handshake edge itself
                addr = (hs && cnt != LAST) ? cnt + 1'b1 : cnt;
                if (hs && cnt == LAST) state_n = IDLE;
            end
            POS_ROW: if (hs) state_n = POS_COL;
            POS_COL: if (hs) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row    <= RRST;
            col    <= CRST;
            cursor <= AW'(CURSOR_RST);
            cnt    <= '0;
            tx     <= '0;
            tx_v   <= 1'b0;
            go     <= 1'b0;
            pend   <= 1'b0;
            drop   <= 1'b0;
        end else begin
            row    <= row_n;
            col    <= col_n;
            cursor <= AW'(row_n) * AW'(COLS) + AW'(col_n);
            drop   <= bus.i_serial_v && busy;
            go     <= (state == IDLE) && (state_n == DUMP);
            pend   <= go || (state == DUMP && hs && cnt != LAST);
            if (state == IDLE)
                cnt <= '0;
            else if (state == CLEAR)
                cnt <= cnt + 1'b1;
            else if (state == DUMP && hs && cnt != LAST)
                cnt <= cnt + 1'b1;
            case (state)
                RSP: if (!tx_v) begin
                    tx   <= rdata;
                    tx_v <= 1'b1;
                end else if (hs) tx_v <= 1'b0;
                DUMP: if (pend) begin
                    tx   <= rdata;
                    tx_v <= 1'b1;
                end else if (hs) tx_v <= 1'b0;
                POS_ROW: if (!tx_v) begin
                    tx   <= DW'(row);
                    tx_v <= 1'b1;
                end else if (hs) tx_v <= 1'b0;
                POS_COL: if (!tx_v) begin
                    tx   <= DW'(col);
                    tx_v <= 1'b1;
                end else if (hs) tx_v <= 1'b0;
                default: ;
            endcase
        end
    end

    // character RAM keeps its contents across reset
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

// File: tb/tb_term_buffer_ctrl.sv
// Bench for term_buffer_ctrl: vector table, hand sequences,
// and random commands against a cell-array reference model.
module tb_term_buffer_ctrl;
    localparam int ROWS = 24;
    localparam int COLS = 40;
    localparam int N    = ROWS * COLS;
    localparam int DW   = 8;
    localparam int AW   = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    term_buffer_ctrl_if #(.DW(DW), .AW(AW)) bus ();

    term_buffer_ctrl #(
        .COLS(COLS), .ROWS(ROWS), .DW(DW), .AW(AW),
        .CURSOR_RST(0), .FILL(8'h20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [7:0] cmd;
        int         cur;
        logic [7:0] rsp;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int drops = 0;
    int rdy_mode = 0;
    int phase = 0;
    logic [7:0] rxq[$];
    logic [7:0] expq[$];
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = '0;

    logic [7:0] mm [N];
    int  mrow = 0;
    int  mcol = 0;
    bit  mw = 0;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rx_at(input int i);
        if (i < rxq.size()) return 32'(rxq[i]);
        return 32'hFFFF_FFFF;
    endfunction

    // reference: cell array plus row/col, straight from the command rules
    function automatic void model_cmd(input logic [7:0] b);
        int lin;
        if (mw) begin
            mm[mrow * COLS + mcol] = b;
            lin  = (mrow * COLS + mcol + 1) % N;
            mrow = lin / COLS;
            mcol = lin % COLS;
            mw   = 0;
            return;
        end
        case (b)
            8'h6A: begin
                if (mrow < ROWS - 1) mrow++;
                expq.push_back(mm[mrow * COLS + mcol]);
            end
            8'h6B: begin
                if (mrow > 0) mrow--;
                expq.push_back(mm[mrow * COLS + mcol]);
            end
            8'h68: begin
                if (mcol > 0) mcol--;
                expq.push_back(mm[mrow * COLS + mcol]);
            end
            8'h6C: begin
                if (mcol < COLS - 1) mcol++;
                expq.push_back(mm[mrow * COLS + mcol]);
            end
            8'h77: mw = 1;
            8'h63: begin
                foreach (mm[i]) mm[i] = 8'h20;
                mrow = 0;
                mcol = 0;
            end
            8'h20: foreach (mm[i]) expq.push_back(mm[i]);
            8'h3F: begin
                expq.push_back(8'(mrow));
                expq.push_back(8'(mcol));
            end
            default: ;
        endcase
    endfunction

    always @(posedge clk) begin
        #1;
        phase = (phase + 1) % 3;
        bus.i_serial_rdy = (rdy_mode == 0) || (phase == 0);
    end

    always @(negedge clk) begin
        if (!rst) begin
            prev_hold = 1'b0;
        end else begin
            if (bus.o_drop) drops++;
            if (prev_hold) begin
                chk("hold_valid", 32'(bus.o_serial_v), 1);
                chk("hold_data", 32'(bus.o_serial), 32'(prev_data));
            end
            if (bus.o_serial_v && bus.i_serial_rdy)
                rxq.push_back(bus.o_serial);
            prev_hold = bus.o_serial_v && !bus.i_serial_rdy;
            prev_data = bus.o_serial;
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.i_serial   = b;
        bus.i_serial_v = 1'b1;
        @(negedge clk);
        bus.i_serial_v = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bus.o_busy || bus.o_serial_v) && n < 10000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10000) chk("idle_timeout", 1, 0);
    endtask

    task automatic wait_rx(input int cnt);
        int n;
        n = 0;
        while (rxq.size() < cnt && n < 10000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10000) chk("rx_timeout", 1, 0);
    endtask

    task automatic compare_rx(input string tag);
        chk({tag, "_count"}, rxq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < rxq.size(); i++)
            chk({tag, "_byte"}, 32'(rxq[i]), 32'(expq[i]));
        chk({tag, "_cursor"}, 32'(bus.o_cursor),
            mrow * COLS + mcol);
        rxq.delete();
        expq.delete();
    endtask

    task automatic run(input logic [7:0] b, input string tag);
        model_cmd(b);
        send(b);
        wait_idle();
        compare_rx(tag);
    endtask

    vec_t vt [7];
    int   n;
    int   r;
    logic [7:0] mv [4];

    initial begin
        vt[0] = '{8'h68, 1,  8'h20};
        vt[1] = '{8'h68, 0,  8'h41};
        vt[2] = '{8'h68, 0,  8'h41};
        vt[3] = '{8'h6B, 0,  8'h41};
        vt[4] = '{8'h6A, 40, 8'h20};
        vt[5] = '{8'h6B, 0,  8'h41};
        vt[6] = '{8'h6C, 1,  8'h20};
        mv[0] = 8'h6A;
        mv[1] = 8'h6B;
        mv[2] = 8'h68;
        mv[3] = 8'h6C;

        bus.i_serial     = '0;
        bus.i_serial_v   = 1'b0;
        bus.i_serial_rdy = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_cursor", 32'(bus.o_cursor), 0);
        chk("reset_busy", 32'(bus.o_busy), 0);
        chk("reset_valid", 32'(bus.o_serial_v), 0);
        chk("reset_serial", 32'(bus.o_serial), 0);
        chk("reset_drop", 32'(bus.o_drop), 0);
        rst = 1'b1;

        model_cmd(8'h63);
        send(8'h63);
        n = 0;
        while (bus.o_busy && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk("clear_busy_cycles", n, 960);
        wait_idle();
        compare_rx("clear");

        run(8'h77, "w_cmd");
        run(8'h41, "w_data");
        chk("write_cursor", 32'(bus.o_cursor), 1);

        model_cmd(8'h6C);
        @(negedge clk);
        bus.i_serial   = 8'h6C;
        bus.i_serial_v = 1'b1;
        @(negedge clk);
        bus.i_serial_v = 1'b0;
        chk("lat_edge0", 32'(bus.o_serial_v), 0);
        @(negedge clk);
        chk("lat_edge1", 32'(bus.o_serial_v), 0);
        @(negedge clk);
        chk("lat_edge2", 32'(bus.o_serial_v), 1);
        chk("lat_data", 32'(bus.o_serial), 32'h20);
        wait_idle();
        compare_rx("move_l");
        chk("cursor_two", 32'(bus.o_cursor), 2);

        for (int i = 0; i < 7; i++) begin
            model_cmd(vt[i].cmd);
            send(vt[i].cmd);
            wait_idle();
            chk("vec_count", rxq.size(), 1);
            chk("vec_rsp", rx_at(0), 32'(vt[i].rsp));
            chk("vec_cursor", 32'(bus.o_cursor), vt[i].cur);
            rxq.delete();
            expq.delete();
        end

        repeat (23) run(8'h6A, "to_end_j");
        repeat (39) run(8'h6C, "to_end_l");
        chk("end_cursor", 32'(bus.o_cursor), 959);
        run(8'h6A, "clamp_j");
        run(8'h6C, "clamp_l");
        chk("clamp_cursor", 32'(bus.o_cursor), 959);
        run(8'h77, "wrap_w");
        run(8'h5A, "wrap_data");
        chk("wrap_cursor", 32'(bus.o_cursor), 0);

        repeat (3) run(8'h6A, "pos_j");
        repeat (7) run(8'h6C, "pos_l");
        rdy_mode = 1;
        model_cmd(8'h3F);
        send(8'h3F);
        wait_idle();
        chk("pos_count", rxq.size(), 2);
        chk("pos_row", rx_at(0), 3);
        chk("pos_col", rx_at(1), 7);
        compare_rx("pos");
        rdy_mode = 0;

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            rdy_mode = $urandom_range(0, 1);
            case (r)
                0, 1, 2, 3: run(mv[r], "rnd_move");
                4, 5: begin
                    run(8'h77, "rnd_w");
                    run(8'($urandom_range(0, 255)), "rnd_data");
                end
                6: run(8'h3F, "rnd_pos");
                7: run(8'h78, "rnd_other");
                default: run(mv[$urandom_range(0, 3)], "rnd_move");
            endcase
        end

        rdy_mode = 0;
        drops = 0;
        model_cmd(8'h20);
        send(8'h20);
        wait_rx(100);
        send(8'h6A);
        wait_idle();
        compare_rx("dump");
        chk("dump_drops", drops, 1);

        model_cmd(8'h20);
        send(8'h20);
        wait_rx(100);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_valid", 32'(bus.o_serial_v), 0);
        chk("rst_busy", 32'(bus.o_busy), 0);
        chk("rst_cursor", 32'(bus.o_cursor), 0);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        rxq.delete();
        expq.delete();
        mrow = 0;
        mcol = 0;
        mw   = 0;
        run(8'h20, "dump_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
